// File: rtl/fracnet_mac_pipe.sv
// rtl/fracnet_mac_pipe.sv - pipelined multiply-accumulate with grouped saturating sums
// Product runs through NUM_STAGE registers, then one accumulate stage and one output stage.
module fracnet_mac_pipe #(
    parameter int DIN0_WIDTH  = 15,
    parameter int DIN1_WIDTH  = 5,
    parameter int ACC_WIDTH   = 24,
    parameter int NUM_STAGE   = 3,
    parameter int SIGNED_MODE = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce,
    input  logic                  in_valid,
    input  logic [DIN0_WIDTH-1:0] din0,
    input  logic [DIN1_WIDTH-1:0] din1,
    input  logic                  acc_clear,
    input  logic                  acc_last,
    output logic                  out_valid,
    output logic [ACC_WIDTH-1:0]  dout,
    output logic                  overflow
);

    localparam int PW = DIN0_WIDTH + DIN1_WIDTH;
    localparam int SW = ACC_WIDTH + 1;
    localparam bit SGN = (SIGNED_MODE != 0);

    logic [PW-1:0] a_ext, b_ext, prod_d;
    logic [PW-1:0] prod_q [NUM_STAGE];
    logic [NUM_STAGE-1:0] vld_q, clr_q, lst_q;

    logic [ACC_WIDTH-1:0] acc_q, acc_d, dout_q;
    logic                 sticky_q, sticky_d, prev_last_q, fin_q, out_valid_q, ovf_q;
    logic                 fresh, ovf;
    logic [SW-1:0]        base, pext, sum;
    logic [PW-1:0]        prod_tail;

    // The low PW bits of the product are the same for signed and unsigned once
    // the operands are extended to PW bits, so one multiplier serves both modes.
    assign a_ext  = {{DIN1_WIDTH{SGN & din0[DIN0_WIDTH-1]}}, din0};
    assign b_ext  = {{DIN0_WIDTH{SGN & din1[DIN1_WIDTH-1]}}, din1};
    assign prod_d = a_ext * b_ext;

    assign prod_tail = prod_q[NUM_STAGE-1];
    assign fresh     = clr_q[NUM_STAGE-1] | prev_last_q;
    assign base      = fresh ? '0 : {SGN & acc_q[ACC_WIDTH-1], acc_q};
    assign pext      = {{(SW-PW){SGN & prod_tail[PW-1]}}, prod_tail};
    assign sum       = base + pext;

    always_comb begin
        ovf   = 1'b0;
        acc_d = sum[ACC_WIDTH-1:0];
        if (SGN) begin
            if (sum[SW-1] != sum[SW-2]) begin
                ovf   = 1'b1;
                acc_d = sum[SW-1] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                  : {1'b0, {(ACC_WIDTH-1){1'b1}}};
            end
        end else if (sum[SW-1]) begin
            ovf   = 1'b1;
            acc_d = '1;
        end
    end

    // Sticky flag restarts with each new group rather than on a literal zero accumulator.
    assign sticky_d = ovf | (fresh ? 1'b0 : sticky_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_STAGE; i++) prod_q[i] <= '0;
            vld_q       <= '0;
            clr_q       <= '0;
            lst_q       <= '0;
            acc_q       <= '0;
            sticky_q    <= 1'b0;
            prev_last_q <= 1'b1;
            fin_q       <= 1'b0;
            out_valid_q <= 1'b0;
            dout_q      <= '0;
            ovf_q       <= 1'b0;
        end else if (ce) begin
            prod_q[0] <= prod_d;
            vld_q[0]  <= in_valid;
            clr_q[0]  <= acc_clear;
            lst_q[0]  <= acc_last;
            for (int i = 1; i < NUM_STAGE; i++) begin
                prod_q[i] <= prod_q[i-1];
                vld_q[i]  <= vld_q[i-1];
                clr_q[i]  <= clr_q[i-1];
                lst_q[i]  <= lst_q[i-1];
            end

            if (vld_q[NUM_STAGE-1]) begin
                acc_q       <= acc_d;
                sticky_q    <= sticky_d;
                prev_last_q <= lst_q[NUM_STAGE-1];
                fin_q       <= lst_q[NUM_STAGE-1];
            end else begin
                fin_q <= 1'b0;
            end

            out_valid_q <= fin_q;
            if (fin_q) begin
                dout_q <= acc_q;
                ovf_q  <= sticky_q;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign dout      = dout_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_fracnet_mac_pipe.sv
// tb/tb_fracnet_mac_pipe.sv - scoreboard bench for fracnet_mac_pipe over three configurations
module tb_fracnet_mac_pipe;

    typedef struct {
        logic [23:0] d;
        logic        o;
        int          cy;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic ce = 1'b1;
    logic iv0 = 1'b0, iv1 = 1'b0, iv2 = 1'b0;
    logic [14:0] din0 = '0;
    logic [4:0]  din1 = '0;
    logic acc_clear = 1'b0, acc_last = 1'b0;

    logic        ov0, ov1, ov2, of0, of1, of2;
    logic [23:0] d0;
    logic [19:0] d1, d2;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic ce_prev = 1'b1;
    logic reset_prev = 1'b1;

    exp_t q0[$], q1[$], q2[$];
    logic        last_ov [3];
    logic [23:0] last_d  [3];
    logic        last_o  [3];

    always #5 clk = ~clk;

    fracnet_mac_pipe u0 (
        .clk(clk), .reset(reset), .ce(ce), .in_valid(iv0), .din0(din0), .din1(din1),
        .acc_clear(acc_clear), .acc_last(acc_last), .out_valid(ov0), .dout(d0), .overflow(of0));

    fracnet_mac_pipe #(.ACC_WIDTH(20)) u1 (
        .clk(clk), .reset(reset), .ce(ce), .in_valid(iv1), .din0(din0), .din1(din1),
        .acc_clear(acc_clear), .acc_last(acc_last), .out_valid(ov1), .dout(d1), .overflow(of1));

    fracnet_mac_pipe #(.ACC_WIDTH(20), .SIGNED_MODE(1)) u2 (
        .clk(clk), .reset(reset), .ce(ce), .in_valid(iv2), .din0(din0), .din1(din1),
        .acc_clear(acc_clear), .acc_last(acc_last), .out_valid(ov2), .dout(d2), .overflow(of2));

    always @(posedge clk) begin
        cyc        <= cyc + 1;
        ce_prev    <= ce;
        reset_prev <= reset;
    end

    task automatic chk(input string name, input logic [23:0] act, input logic [23:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, want);
        end
    endtask

    function automatic int qsize(input int id);
        case (id)
            0: return q0.size();
            1: return q1.size();
            default: return q2.size();
        endcase
    endfunction

    task automatic mon(input int id, input logic ov, input logic [23:0] d, input logic o);
        exp_t e;
        if (!reset_prev) begin
            if (!ce_prev) begin
                checks++;
                if (ov !== last_ov[id] || d !== last_d[id] || o !== last_o[id]) begin
                    errors++;
                    $display("FAIL hold%0d: got v=%0b d=%0d o=%0b expected v=%0b d=%0d o=%0b",
                             id, ov, d, o, last_ov[id], last_d[id], last_o[id]);
                end
            end else if (ov === 1'b1) begin
                checks++;
                if (qsize(id) == 0) begin
                    errors++;
                    $display("FAIL unexpected%0d: got out_valid=1 d=%0d expected no output", id, d);
                end else begin
                    case (id)
                        0: e = q0.pop_front();
                        1: e = q1.pop_front();
                        default: e = q2.pop_front();
                    endcase
                    if (d !== e.d || o !== e.o || (e.cy >= 0 && cyc != e.cy)) begin
                        errors++;
                        $display("FAIL result%0d: got d=%0d o=%0b cyc=%0d expected d=%0d o=%0b cyc=%0d",
                                 id, d, o, cyc, e.d, e.o, e.cy);
                    end
                end
            end
        end
        last_ov[id] = ov;
        last_d[id]  = d;
        last_o[id]  = o;
    endtask

    always @(negedge clk) begin
        mon(0, ov0, d0, of0);
        mon(1, ov1, {4'd0, d1}, of1);
        mon(2, ov2, {4'd0, d2}, of2);
    end

    task automatic expect_out(input int id, input logic [23:0] d, input logic o, input int cy);
        exp_t e;
        e.d = d; e.o = o; e.cy = cy;
        case (id)
            0: q0.push_back(e);
            1: q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    task automatic drive(input int id, input bit c, input bit v, input int a, input int b,
                         input bit clr, input bit lst);
        ce        = c;
        iv0       = (id == 0) && v;
        iv1       = (id == 1) && v;
        iv2       = (id == 2) && v;
        din0      = a[14:0];
        din1      = b[4:0];
        acc_clear = clr;
        acc_last  = lst;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 1, 0, 0, 0, 0, 0);
    endtask

    task automatic chk_reset_outs();
        chk("rst_v0", {23'd0, ov0}, 24'd0);
        chk("rst_d0", d0, 24'd0);
        chk("rst_o0", {23'd0, of0}, 24'd0);
        chk("rst_v1", {23'd0, ov1}, 24'd0);
        chk("rst_d1", {4'd0, d1}, 24'd0);
        chk("rst_o1", {23'd0, of1}, 24'd0);
        chk("rst_v2", {23'd0, ov2}, 24'd0);
        chk("rst_d2", {4'd0, d2}, 24'd0);
        chk("rst_o2", {23'd0, of2}, 24'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held two cycles while random elements are offered.
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            ce        = 1'b1;
            iv0       = 1'($urandom);
            iv1       = 1'($urandom);
            iv2       = 1'($urandom);
            din0      = 15'($urandom);
            din1      = 5'($urandom);
            acc_clear = 1'($urandom);
            acc_last  = 1'($urandom);
            @(posedge clk);
            #1;
            chk_reset_outs();
        end
        reset = 1'b0;
        idle(1);
        chk_reset_outs();
        idle(4);

        // Unsigned dot product with exact latency check.
        drive(0, 1, 1, 100, 3, 1, 0);
        drive(0, 1, 1, 200, 5, 0, 0);
        drive(0, 1, 1, 7, 31, 0, 1);
        expect_out(0, 24'd1517, 1'b0, cyc + 4);
        idle(6);

        // Fresh start without clear after a completed group; widest operands.
        drive(0, 1, 1, 2, 3, 0, 1);
        expect_out(0, 24'd6, 1'b0, cyc + 4);
        drive(0, 1, 1, 32767, 31, 1, 1);
        expect_out(0, 24'd1015777, 1'b0, cyc + 4);
        idle(6);

        // Unsigned saturation, then a back-to-back single-term group.
        drive(1, 1, 1, 32767, 31, 1, 0);
        drive(1, 1, 1, 32767, 31, 0, 1);
        expect_out(1, 24'd1048575, 1'b1, cyc + 4);
        drive(1, 1, 1, 1, 1, 1, 1);
        expect_out(1, 24'd1, 1'b0, cyc + 4);
        idle(6);

        // Signed accumulation and signed positive saturation.
        drive(2, 1, 1, -5, 7, 1, 0);
        drive(2, 1, 1, 3, -2, 0, 1);
        expect_out(2, 24'hFFFD7, 1'b0, cyc + 4);
        idle(6);
        drive(2, 1, 1, -16384, -16, 1, 0);
        drive(2, 1, 1, -16384, -16, 0, 0);
        drive(2, 1, 1, -16384, -16, 0, 0);
        drive(2, 1, 1, -16384, -16, 0, 1);
        expect_out(2, 24'h7FFFF, 1'b1, cyc + 4);
        idle(6);

        // Stall: ce toggles, invalid offers during ce=0 must be ignored.
        drive(0, 1, 1, 10, 2, 1, 0);
        drive(0, 0, 1, 999, 31, 0, 1);
        drive(0, 1, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        drive(0, 1, 1, 20, 3, 0, 0);
        drive(0, 0, 1, 5, 5, 1, 1);
        drive(0, 1, 1, 30, 4, 0, 1);
        expect_out(0, 24'd200, 1'b0, -1);
        for (int i = 0; i < 14; i++) drive(0, bit'(i % 2), 0, 0, 0, 0, 0);
        idle(4);

        // Reset with a complete group still in flight.
        drive(0, 1, 1, 5, 5, 1, 0);
        drive(0, 1, 1, 6, 6, 0, 1);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        drive(0, 1, 1, 4, 4, 1, 1);
        expect_out(0, 24'd16, 1'b0, cyc + 4);
        idle(10);

        for (int id = 0; id < 3; id++) begin
            checks++;
            if (qsize(id) != 0) begin
                errors++;
                $display("FAIL drain%0d: got %0d pending expected 0", id, qsize(id));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
